// File: rtl/dmem_pipe.sv
// dmem_pipe: byte-lane data memory with a one-entry write buffer, forwarding reads
// and a post-reset zero-fill sequencer.
module dmem_pipe #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 16,
    localparam int LANES = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic              ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [LANES-1:0]  wr_be,
    output logic              addr_err
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                pb_valid_q, pb_valid_d;
    logic [ADDR_W-1:0]   pb_addr_q, pb_addr_d;
    logic [DATA_W-1:0]   pb_data_q, pb_data_d;
    logic [LANES-1:0]    pb_be_q, pb_be_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                addr_err_q, addr_err_d;
    logic [DATA_W-1:0]   merged;
    logic                run, rd_ok, wr_ok;

    assign run      = (state_q == RUN);
    assign rd_ok    = 32'(rd_addr) < DEPTH;
    assign wr_ok    = 32'(wr_addr) < DEPTH;
    assign ready    = run;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign addr_err = addr_err_q;

    // Later assignments win: same-cycle write over buffered write over array.
    always_comb begin
        merged = mem[rd_addr[IW-1:0]];
        for (int i = 0; i < LANES; i++) begin
            if (pb_valid_q && pb_addr_q == rd_addr && pb_be_q[i]) merged[8*i+:8] = pb_data_q[8*i+:8];
            if (wr_en && wr_addr == rd_addr && wr_be[i]) merged[8*i+:8] = wr_data[8*i+:8];
        end
    end

    always_comb begin
        state_d    = (state_q == CLEAR && cnt_q == IW'(DEPTH - 1)) ? RUN : state_q;
        cnt_d      = (state_q == CLEAR) ? cnt_q + 1'b1 : cnt_q;
        pb_valid_d = run && wr_en && wr_ok;
        pb_addr_d  = wr_addr;
        pb_data_d  = wr_data;
        pb_be_d    = wr_be;
        rd_valid_d = run && rd_en;
        rd_data_d  = (run && rd_en) ? (rd_ok ? merged : '0) : rd_data_q;
        addr_err_d = run && ((rd_en && !rd_ok) || (wr_en && !wr_ok));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            pb_valid_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pb_valid_q <= pb_valid_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_ff @(posedge clk) begin
        pb_addr_q <= pb_addr_d;
        pb_data_q <= pb_data_d;
        pb_be_q   <= pb_be_d;
    end

    // A pending write caught by reset is dropped, not committed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem[cnt_q] <= '0;
            end else if (pb_valid_q) begin
                for (int i = 0; i < LANES; i++)
                    if (pb_be_q[i]) mem[pb_addr_q[IW-1:0]][8*i+:8] <= pb_data_q[8*i+:8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_pipe.sv
// tb_dmem_pipe: directed scenario tasks plus a randomised run against a
// write-immediately reference array for dmem_pipe (DATA_W=16, DEPTH=16).
module tb_dmem_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        rd_en;
    logic [10:0] rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        addr_err;

    int passed = 0;
    int total  = 0;

    dmem_pipe dut (
        .clk(clk), .reset(reset), .ready(ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rd_en = 1'b0; rd_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic rd(input logic [10:0] a);
        idle();
        rd_en = 1'b1; rd_addr = a;
        tick();
    endtask

    task automatic test_reset;
        int n;
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({ready, rd_valid, rd_data, addr_err} !== 19'h0)
            $display("FAIL reset_state got=%h exp=0", {ready, rd_valid, rd_data, addr_err});
        else passed++;
        wait_ready(n);
        total++;
        if (n !== 16) $display("FAIL clear_len got=%0d exp=16", n); else passed++;
        for (int a = 0; a < 16; a++) begin
            rd(11'(a));
            total++;
            if ({rd_valid, rd_data} !== {1'b1, 16'h0000})
                $display("FAIL zero_fill addr=%0d got=%b/%h exp=1/0000", a, rd_valid, rd_data);
            else passed++;
        end
        idle();
    endtask

    task automatic test_forward;
        idle();
        wr_en = 1'b1; wr_addr = 11'd4; wr_data = 16'h5A5A; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 11'd4;
        tick();
        total++;
        if ({rd_valid, rd_data} !== {1'b1, 16'h5A5A})
            $display("FAIL fwd_same got=%b/%h exp=1/5a5a", rd_valid, rd_data);
        else passed++;
        rd(11'd4);
        total++;
        if ({rd_valid, rd_data} !== {1'b1, 16'h5A5A})
            $display("FAIL fwd_buf got=%b/%h exp=1/5a5a", rd_valid, rd_data);
        else passed++;
        idle();
        tick();
        total++;
        if ({rd_valid, rd_data} !== {1'b0, 16'h5A5A})
            $display("FAIL rd_hold got=%b/%h exp=0/5a5a", rd_valid, rd_data);
        else passed++;
        rd(11'd4);
        total++;
        if ({rd_valid, rd_data} !== {1'b1, 16'h5A5A})
            $display("FAIL fwd_array got=%b/%h exp=1/5a5a", rd_valid, rd_data);
        else passed++;
        idle();
    endtask

    task automatic test_byte_lane;
        idle();
        wr_en = 1'b1; wr_addr = 11'd5; wr_data = 16'h6767; wr_be = 2'b11;
        tick();
        wr_data = 16'h00FF; wr_be = 2'b01;
        rd_en = 1'b1; rd_addr = 11'd5;
        tick();
        total++;
        if (rd_data !== 16'h67FF) $display("FAIL lane_merge got=%h exp=67ff", rd_data); else passed++;
        wr_data = 16'h0000; wr_be = 2'b00;
        tick();
        total++;
        if (rd_data !== 16'h67FF) $display("FAIL be_zero got=%h exp=67ff", rd_data); else passed++;
        idle();
        tick();
        tick();
        rd(11'd5);
        total++;
        if (rd_data !== 16'h67FF) $display("FAIL lane_array got=%h exp=67ff", rd_data); else passed++;
        idle();
    endtask

    task automatic test_addr_err;
        idle();
        wr_en = 1'b1; wr_addr = 11'd16; wr_data = 16'hFFFF; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 11'd20;
        tick();
        total++;
        if ({addr_err, rd_valid, rd_data} !== {1'b1, 1'b1, 16'h0})
            $display("FAIL oor got=%b/%b/%h exp=1/1/0000", addr_err, rd_valid, rd_data);
        else passed++;
        idle();
        tick();
        total++;
        if ({addr_err, rd_valid} !== 2'b00) $display("FAIL err_pulse got=%b exp=00", {addr_err, rd_valid}); else passed++;
        tick();
        rd(11'd0);
        total++;
        if ({addr_err, rd_data} !== {1'b0, 16'h0}) $display("FAIL oor_alias got=%b/%h exp=0/0000", addr_err, rd_data); else passed++;
        wr_en = 1'b1; wr_addr = 11'd2047; wr_be = 2'b11; wr_data = 16'h1111;
        tick();
        total++;
        if (addr_err !== 1'b1) $display("FAIL wr_oor_err got=%b exp=1", addr_err); else passed++;
        idle();
    endtask

    task automatic test_back_to_back;
        idle();
        wr_en = 1'b1; wr_addr = 11'd9; wr_data = 16'h1111; wr_be = 2'b11;
        tick();
        wr_data = 16'h2222;
        tick();
        wr_addr = 11'd10; wr_data = 16'hABCD;
        rd_en = 1'b1; rd_addr = 11'd4;
        tick();
        total++;
        if ({rd_valid, rd_data} !== {1'b1, 16'h5A5A}) $display("FAIL indep_rw got=%b/%h exp=1/5a5a", rd_valid, rd_data); else passed++;
        idle();
        tick();
        rd(11'd9);
        total++;
        if (rd_data !== 16'h2222) $display("FAIL later_wins got=%h exp=2222", rd_data); else passed++;
        rd(11'd10);
        total++;
        if (rd_data !== 16'hABCD) $display("FAIL indep_wr got=%h exp=abcd", rd_data); else passed++;
        idle();
    endtask

    task automatic test_reset_discard;
        int n;
        idle();
        wr_en = 1'b1; wr_addr = 11'd3; wr_data = 16'h1234; wr_be = 2'b11;
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (ready !== 1'b0) $display("FAIL ready_drop got=%b exp=0", ready); else passed++;
        wait_ready(n);
        total++;
        if (n !== 16) $display("FAIL refill_len got=%0d exp=16", n); else passed++;
        rd(11'd3);
        total++;
        if ({rd_valid, rd_data} !== {1'b1, 16'h0}) $display("FAIL discard got=%b/%h exp=1/0000", rd_valid, rd_data); else passed++;
        idle();
    endtask

    task automatic test_clear_ignored;
        int n;
        int bad;
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n = 0;
        bad = 0;
        while (!ready && n < 100) begin
            rd_en = 1'b1; rd_addr = 11'd20;
            wr_en = 1'b1; wr_addr = 11'd7; wr_data = 16'hFFFF; wr_be = 2'b11;
            tick();
            if (rd_valid !== 1'b0 || addr_err !== 1'b0) bad++;
            n++;
        end
        total++;
        if (bad !== 0 || n !== 16) $display("FAIL clear_ignore bad=%0d cycles=%0d exp=0/16", bad, n); else passed++;
        idle();
        tick();
        rd(11'd7);
        total++;
        if (rd_data !== 16'h0) $display("FAIL clear_no_write got=%h exp=0000", rd_data); else passed++;
        idle();
    endtask

    task automatic test_random;
        logic [15:0] ref_mem [16];
        logic [15:0] exp_d;
        logic        exp_v, exp_e;
        int          n;
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_ready(n);
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        exp_d = '0;
        for (int c = 0; c < 10000; c++) begin
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = 11'($urandom_range(0, 19));
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 11'($urandom_range(0, 19));
            wr_data = 16'($urandom);
            wr_be   = 2'($urandom_range(0, 3));
            if (wr_en && wr_addr < 11'd16)
                for (int b = 0; b < 2; b++)
                    if (wr_be[b]) ref_mem[wr_addr[3:0]][8*b+:8] = wr_data[8*b+:8];
            exp_v = rd_en;
            if (rd_en) exp_d = (rd_addr < 11'd16) ? ref_mem[rd_addr[3:0]] : 16'h0;
            exp_e = (rd_en && rd_addr >= 11'd16) || (wr_en && wr_addr >= 11'd16);
            tick();
            total++;
            if ({rd_valid, rd_data, addr_err} !== {exp_v, exp_d, exp_e})
                $display("FAIL random cyc=%0d got=%b/%h/%b exp=%b/%h/%b",
                         c, rd_valid, rd_data, addr_err, exp_v, exp_d, exp_e);
            else passed++;
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        test_reset();
        test_forward();
        test_byte_lane();
        test_addr_err();
        test_back_to_back();
        test_reset_discard();
        test_clear_ignored();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
